write_back: RTL and testbench

- Write-back stage of the multicycle MIPS datapath.
- Selects the register-file write value from one of three sources: the memory read data (with load-size extraction and extension), the ALU result, or the link address.
- Provides the selection combinationally on writeData.
- Also presents a registered, one-cycle-delayed register-file write port (enable, address, data) that guards against writes to $0.

---
 rtl/write_back_if.sv | 30 +++
 rtl/write_back.sv | 48 ++++
 tb/tb_write_back.sv | 126 ++++++++++++
 3 files changed

// File: rtl/write_back_if.sv
// write_back_if: write-back stage bundle (selection controls, load data, rf write port)
// master: drives controls/data, observes writeData and the rf_* port
// slave:  consumes controls/data, produces writeData and the rf_* port
interface write_back_if #(parameter int DATA_W = 32);
  logic              MemtoReg;
  logic [DATA_W-1:0] readData;
  logic [DATA_W-1:0] ALUResult;
  logic [1:0]        LoadSize;
  logic              LoadUnsigned;
  logic              Link;
  logic [DATA_W-1:0] PCPlus4;
  logic [1:0]        RegDst;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic              RegWrite;
  logic [DATA_W-1:0] writeData;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  modport master (
    output MemtoReg, readData, ALUResult, LoadSize, LoadUnsigned, Link, PCPlus4,
           RegDst, rt, rd, RegWrite,
    input  writeData, rf_we, rf_waddr, rf_wdata
  );
  modport slave (
    input  MemtoReg, readData, ALUResult, LoadSize, LoadUnsigned, Link, PCPlus4,
           RegDst, rt, rd, RegWrite,
    output writeData, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/write_back.sv
// write_back: MIPS write-back select with sub-word load extension and a registered, $0-guarded rf write port
// clk   : rising-edge clock for the rf_* registers
// rst_n : asynchronous active-low reset, clears rf_we/rf_waddr/rf_wdata
// wb    : write_back_if slave (controls and data in, writeData and rf_* out)
module write_back #(
  parameter int         DATA_W   = 32,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input logic       clk,
  input logic       rst_n,
  write_back_if.slave wb
);
  logic [15:0]       half_c;
  logic [7:0]        byte_c;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] wdata_c;
  logic [4:0]        waddr_c;
  logic              rf_we_d, rf_we_q;
  logic [4:0]        rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  // Lane muxes use only the byte address, so unselected lanes never leak into the result.
  always_comb begin
    half_c  = wb.ALUResult[1] ? wb.readData[31:16] : wb.readData[15:0];
    byte_c  = wb.ALUResult[1] ? (wb.ALUResult[0] ? wb.readData[31:24] : wb.readData[23:16])
                              : (wb.ALUResult[0] ? wb.readData[15:8]  : wb.readData[7:0]);
    load_c  = (wb.LoadSize == 2'b01) ? {{16{~wb.LoadUnsigned & half_c[15]}}, half_c} :
              (wb.LoadSize == 2'b10) ? {{24{~wb.LoadUnsigned & byte_c[7]}}, byte_c} :
                                       wb.readData;
    wdata_c = wb.Link ? wb.PCPlus4 : (wb.MemtoReg ? load_c : wb.ALUResult);
    waddr_c = (wb.RegDst == 2'b00) ? wb.rt : (wb.RegDst == 2'b01) ? wb.rd : LINK_REG;
    rf_we_d = wb.RegWrite && (waddr_c != 5'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= waddr_c;
      rf_wdata_q <= wdata_c;
    end
  end
  assign wb.writeData = wdata_c;
  assign wb.rf_we     = rf_we_q;
  assign wb.rf_waddr  = rf_waddr_q;
  assign wb.rf_wdata  = rf_wdata_q;
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed and random checks of write_back with a scoreboard on the rf port
module tb_write_back;
  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  write_back_if bus ();
  write_back dut (.clk(clk), .rst_n(rst_n), .wb(bus.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model_wd();
    logic [31:0] v;
    if (bus.Link) return bus.PCPlus4;
    if (!bus.MemtoReg) return bus.ALUResult;
    if (bus.LoadSize == 2'b01) begin
      v = (bus.readData >> (int'(bus.ALUResult[1]) * 16)) & 32'h0000FFFF;
      if (!bus.LoadUnsigned && v[15]) v = v | 32'hFFFF0000;
    end else if (bus.LoadSize == 2'b10) begin
      v = (bus.readData >> (int'(bus.ALUResult[1:0]) * 8)) & 32'h000000FF;
      if (!bus.LoadUnsigned && v[7]) v = v | 32'hFFFFFF00;
    end else v = bus.readData;
    return v;
  endfunction
  function automatic logic [4:0] model_wa();
    if (bus.RegDst == 2'b00) return bus.rt;
    if (bus.RegDst == 2'b01) return bus.rd;
    return 5'd31;
  endfunction
  task automatic step(input string tag);
    exp_t e;
    e.a  = model_wa();
    e.d  = model_wd();
    e.we = bus.RegWrite && (e.a != 5'd0);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".we"}, 32'(bus.rf_we), 32'(e.we));
    chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(e.a));
    chk({tag, ".wdata"}, bus.rf_wdata, e.d);
    @(negedge clk);
  endtask
  initial begin
    bus.MemtoReg = 0; bus.readData = 0; bus.ALUResult = 0; bus.LoadSize = 0;
    bus.LoadUnsigned = 0; bus.Link = 0; bus.PCPlus4 = 0; bus.RegDst = 0;
    bus.rt = 0; bus.rd = 0; bus.RegWrite = 0;
    #3;
    chk("rst.we", 32'(bus.rf_we), 32'd0);
    chk("rst.waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst.wdata", bus.rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.readData = 32'h12153524;
    #1 chk("basic.alu", bus.writeData, 32'h00000000);
    bus.MemtoReg = 1;
    #1 chk("basic.mem", bus.writeData, 32'h12153524);
    step("basic");
    bus.readData = 32'h80FF7F01; bus.LoadSize = 2'b10; bus.ALUResult = 32'h1;
    #1 chk("lb.1", bus.writeData, 32'h0000007F);
    bus.ALUResult = 32'h2;
    #1 chk("lb.2", bus.writeData, 32'hFFFFFFFF);
    bus.LoadSize = 2'b01;
    #1 chk("lh.s", bus.writeData, 32'hFFFF80FF);
    bus.LoadUnsigned = 1;
    #1 chk("lh.u", bus.writeData, 32'h000080FF);
    bus.LoadSize = 2'b10; bus.ALUResult = 32'h3;
    #1 chk("lbu.3", bus.writeData, 32'h00000080);
    bus.LoadSize = 2'b11; bus.ALUResult = 32'h2;
    #1 chk("lw.11", bus.writeData, 32'h80FF7F01);
    step("subword");
    bus.Link = 1; bus.PCPlus4 = 32'h00400008; bus.RegDst = 2'b10; bus.RegWrite = 1;
    #1 chk("link.wd", bus.writeData, 32'h00400008);
    step("link");
    chk("link.we", 32'(bus.rf_we), 32'd1);
    chk("link.waddr", 32'(bus.rf_waddr), 32'd31);
    chk("link.wdata", bus.rf_wdata, 32'h00400008);
    bus.Link = 0; bus.MemtoReg = 0; bus.RegDst = 2'b00; bus.rt = 0; bus.ALUResult = 32'hDEADBEEF;
    step("zero");
    chk("zero.we", 32'(bus.rf_we), 32'd0);
    chk("zero.wdata", bus.rf_wdata, 32'hDEADBEEF);
    bus.RegDst = 2'b01; bus.rd = 5'd9;
    #1 chk("lat.pre", 32'(bus.rf_we), 32'd0);
    step("lat1");
    chk("lat.we1", 32'(bus.rf_we), 32'd1);
    chk("lat.waddr", 32'(bus.rf_waddr), 32'd9);
    bus.RegWrite = 0;
    step("lat2");
    chk("lat.we0", 32'(bus.rf_we), 32'd0);
    bus.RegWrite = 1;
    step("prerst");
    rst_n = 1'b0;
    #1;
    chk("arst.we", 32'(bus.rf_we), 32'd0);
    chk("arst.waddr", 32'(bus.rf_waddr), 32'd0);
    chk("arst.wdata", bus.rf_wdata, 32'd0);
    @(posedge clk);
    #1 chk("hold.we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("postrst");
    chk("postrst.we", 32'(bus.rf_we), 32'd1);
    for (int i = 0; i < 40; i++) begin
      bus.MemtoReg = 1'($urandom); bus.readData = $urandom; bus.ALUResult = $urandom;
      bus.LoadSize = 2'($urandom); bus.LoadUnsigned = 1'($urandom);
      bus.Link = ($urandom_range(0, 3) == 0); bus.PCPlus4 = $urandom;
      bus.RegDst = 2'($urandom); bus.rt = 5'($urandom_range(0, 3));
      bus.rd = 5'($urandom); bus.RegWrite = 1'($urandom);
      #1 chk("rnd.wd", bus.writeData, model_wd());
      step("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
